// File: rtl/mont_modexp_seq.sv
// Left-to-right square-and-multiply sequencer for RSA modular exponentiation.
// Drives an external Montgomery multiplier over a start/done handshake. The
// base and "one" arrive already in Montgomery form; a final multiply by 1
// takes the accumulator back to the normal domain.
//
// Ports:
//   clk, rst        clock (posedge), asynchronous active-high reset
//   start           1-cycle request, sampled only while idle
//   base_m, one_m   base and R mod n in Montgomery form, latched on start
//   exp, exp_len    exponent and its significant length (clamped to WIDTH)
//   mm_start        1-cycle launch pulse to the multiplier
//   mm_a, mm_b      multiplier operands, held until mm_done
//   mm_done, mm_res multiplier completion pulse and result
//   busy            high while an exponentiation is in flight
//   done, result    completion pulse and base^exp mod n (held until next start)
module mont_modexp_seq #(
  parameter int unsigned WIDTH = 2048,
  parameter int unsigned LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] base_m,
  input  logic [WIDTH-1:0] one_m,
  input  logic [WIDTH-1:0] exp,
  input  logic [LEN_W-1:0] exp_len,
  output logic             mm_start,
  output logic [WIDTH-1:0] mm_a,
  output logic [WIDTH-1:0] mm_b,
  input  logic             mm_done,
  input  logic [WIDTH-1:0] mm_res,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int unsigned IDX_W = $clog2(WIDTH + 1);
  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SQR,
    S_SQR_W,
    S_MUL,
    S_MUL_W,
    S_CONV,
    S_CONV_W
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   base_q, base_d;
  logic [WIDTH-1:0]   exp_q, exp_d;
  logic               mm_start_q, mm_start_d;
  logic [WIDTH-1:0]   mm_a_q, mm_a_d;
  logic [WIDTH-1:0]   mm_b_q, mm_b_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [IDX_W-1:0]   len_idx;
  logic [IDX_W-1:0]   idx_m1;
  logic               exp_bit;

  // Exponent length clamped to the operand width.
  always_comb begin
    if (32'(exp_len) > 32'(WIDTH)) begin
      len_idx = IDX_W'(WIDTH);
    end else begin
      len_idx = IDX_W'(exp_len);
    end
  end

  // Bit consumed by the square that is completing; only used while idx_q >= 1.
  assign idx_m1  = idx_q - IDX_W'(1);
  assign exp_bit = exp_q[idx_m1[BIT_W-1:0]];

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    base_d     = base_q;
    exp_d      = exp_q;
    mm_start_d = 1'b0;
    mm_a_d     = mm_a_q;
    mm_b_d     = mm_b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    result_d   = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_m;
          exp_d   = exp;
          acc_d   = one_m;
          idx_d   = len_idx;
          busy_d  = 1'b1;
          state_d = (len_idx == '0) ? S_CONV : S_SQR;
        end
      end
      S_SQR: begin
        mm_a_d     = acc_q;
        mm_b_d     = acc_q;
        mm_start_d = 1'b1;
        state_d    = S_SQR_W;
      end
      S_SQR_W: begin
        if (mm_done) begin
          acc_d = mm_res;
          idx_d = idx_m1;
          if (exp_bit) begin
            state_d = S_MUL;
          end else if (idx_m1 == '0) begin
            state_d = S_CONV;
          end else begin
            state_d = S_SQR;
          end
        end
      end
      S_MUL: begin
        mm_a_d     = acc_q;
        mm_b_d     = base_q;
        mm_start_d = 1'b1;
        state_d    = S_MUL_W;
      end
      S_MUL_W: begin
        if (mm_done) begin
          acc_d   = mm_res;
          state_d = (idx_q == '0) ? S_CONV : S_SQR;
        end
      end
      S_CONV: begin
        mm_a_d     = acc_q;
        mm_b_d     = WIDTH'(1);
        mm_start_d = 1'b1;
        state_d    = S_CONV_W;
      end
      S_CONV_W: begin
        // Stay here through the done pulse so a start coinciding with it is ignored.
        if (done_q) begin
          state_d = S_IDLE;
        end else if (mm_done) begin
          result_d = mm_res;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      idx_q      <= '0;
      base_q     <= '0;
      exp_q      <= '0;
      mm_start_q <= 1'b0;
      mm_a_q     <= '0;
      mm_b_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      idx_q      <= idx_d;
      base_q     <= base_d;
      exp_q      <= exp_d;
      mm_start_q <= mm_start_d;
      mm_a_q     <= mm_a_d;
      mm_b_q     <= mm_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      result_q   <= result_d;
    end
  end

  assign mm_start = mm_start_q;
  assign mm_a     = mm_a_q;
  assign mm_b     = mm_b_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule

// File: tb/tb_mont_modexp_seq.sv
// Directed bench for mont_modexp_seq at WIDTH=16 with a mod-1000 multiplier
// model (R=1) that answers 5 cycles after each mm_start.
module tb_mont_modexp_seq;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned LEN_W = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] base_m = '0;
  logic [WIDTH-1:0] one_m = '0;
  logic [WIDTH-1:0] exp = '0;
  logic [LEN_W-1:0] exp_len = '0;
  logic             mm_start;
  logic [WIDTH-1:0] mm_a;
  logic [WIDTH-1:0] mm_b;
  logic             mm_done;
  logic [WIDTH-1:0] mm_res;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  logic             model_done = 1'b0;
  logic             stray_done = 1'b0;
  logic [WIDTH-1:0] model_res = '0;
  logic [WIDTH-1:0] ma = '0;
  logic [WIDTH-1:0] mb = '0;
  logic [WIDTH-1:0] last_a = '0;
  logic [WIDTH-1:0] last_b = '0;
  int               mcnt = 0;
  int               start_cnt = 0;
  int               done_cnt = 0;

  int               n_cmp = 0;
  int               n_fail = 0;

  assign mm_done = model_done | stray_done;
  assign mm_res  = model_res;

  mont_modexp_seq #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .base_m   (base_m),
    .one_m    (one_m),
    .exp      (exp),
    .exp_len  (exp_len),
    .mm_start (mm_start),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .mm_done  (mm_done),
    .mm_res   (mm_res),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  // Multiplier model and pulse counters, all on the falling edge.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (mcnt != 0) begin
      mcnt = mcnt - 1;
      if (mcnt == 0) begin
        model_done = 1'b1;
        model_res  = 16'((32'(ma) * 32'(mb)) % 32'd1000);
      end
    end
    if (mm_start) begin
      ma        = mm_a;
      mb        = mm_b;
      last_a    = mm_a;
      last_b    = mm_b;
      mcnt      = 5;
      start_cnt = start_cnt + 1;
    end
    if (done) done_cnt = done_cnt + 1;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int max_cyc, output bit got);
    got = 1'b0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(posedge clk);
      #1;
      if (done) got = 1'b1;
    end
  endtask

  task automatic run_op(input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] o,
                        input logic [WIDTH-1:0] e, input logic [LEN_W-1:0] l,
                        input int max_cyc, output bit got);
    base_m  = b;
    one_m   = o;
    exp     = e;
    exp_len = l;
    start   = 1'b1;
    cyc(1);
    start   = 1'b0;
    wait_done(max_cyc, got);
  endtask

  task automatic test_reset();
    cyc(3);
    n_cmp++;
    if ({mm_start, busy, done} !== 3'b000 || result !== '0 || mm_a !== '0 || mm_b !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got start/busy/done=%b result=%0d a=%0d b=%0d required all 0",
               {mm_start, busy, done}, result, mm_a, mm_b);
    end
    rst = 1'b0;
    cyc(20);
    n_cmp++;
    if (start_cnt !== 0) begin
      n_fail++;
      $display("FAIL reset_idle_quiet: got %0d mm_start pulses required 0", start_cnt);
    end
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    n_cmp++;
    if ({mm_start, busy, done} !== 3'b000 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got start/busy/done=%b result=%0d required 0",
               {mm_start, busy, done}, result);
    end
  endtask

  task automatic test_basic();
    int c0, d0;
    bit got;
    c0 = start_cnt;
    d0 = done_cnt;
    run_op(16'd3, 16'd1, 16'd11, 6'd4, 500, got);
    n_cmp++;
    if (!got || result !== 16'd147) begin
      n_fail++;
      $display("FAIL basic_result: got done=%0d result=%0d required done=1 result=147", got, result);
    end
    cyc(1);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_width: got done=%b busy=%b required 0/0", done, busy);
    end
    cyc(3);
    n_cmp++;
    if (start_cnt - c0 !== 8) begin
      n_fail++;
      $display("FAIL basic_mm_count: got %0d required 8", start_cnt - c0);
    end
    n_cmp++;
    if (done_cnt - d0 !== 1) begin
      n_fail++;
      $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_high_bits();
    int c0;
    bit got;
    c0 = start_cnt;
    run_op(16'd3, 16'd1, 16'hFF0B, 6'd4, 500, got);
    cyc(3);
    n_cmp++;
    if (!got || result !== 16'd147 || start_cnt - c0 !== 8) begin
      n_fail++;
      $display("FAIL high_bits_ignored: got done=%0d result=%0d pulses=%0d required 1/147/8",
               got, result, start_cnt - c0);
    end
  endtask

  task automatic test_zero_len();
    int c0;
    bit got;
    c0 = start_cnt;
    run_op(16'd9, 16'd1, 16'h5555, 6'd0, 100, got);
    cyc(3);
    n_cmp++;
    if (!got || result !== 16'd1) begin
      n_fail++;
      $display("FAIL zero_len_result: got done=%0d result=%0d required 1/1", got, result);
    end
    n_cmp++;
    if (start_cnt - c0 !== 1 || last_a !== 16'd1 || last_b !== 16'd1) begin
      n_fail++;
      $display("FAIL zero_len_conv: got pulses=%0d a=%0d b=%0d required 1/1/1",
               start_cnt - c0, last_a, last_b);
    end
  endtask

  task automatic test_clamp();
    int c0;
    bit got;
    c0 = start_cnt;
    run_op(16'd3, 16'd1, 16'hFFFF, 6'd20, 2000, got);
    cyc(3);
    n_cmp++;
    if (!got || result !== 16'd707) begin
      n_fail++;
      $display("FAIL clamp_result: got done=%0d result=%0d required 1/707", got, result);
    end
    n_cmp++;
    if (start_cnt - c0 !== 33) begin
      n_fail++;
      $display("FAIL clamp_mm_count: got %0d required 33", start_cnt - c0);
    end
  endtask

  task automatic test_busy_ignore();
    int c0;
    bit got;
    c0 = start_cnt;
    base_m  = 16'd3;
    one_m   = 16'd1;
    exp     = 16'd11;
    exp_len = 6'd4;
    start   = 1'b1;
    cyc(1);
    start   = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_start: got %b required 1", busy);
    end
    cyc(10);
    base_m  = 16'd7;
    exp     = 16'hFFFF;
    exp_len = 6'd16;
    start   = 1'b1;
    cyc(1);
    start   = 1'b0;
    wait_done(500, got);
    cyc(3);
    n_cmp++;
    if (!got || result !== 16'd147 || start_cnt - c0 !== 8) begin
      n_fail++;
      $display("FAIL busy_start_ignored: got done=%0d result=%0d pulses=%0d required 1/147/8",
               got, result, start_cnt - c0);
    end
  endtask

  task automatic test_stray_done();
    int c0, d0;
    c0 = start_cnt;
    d0 = done_cnt;
    stray_done = 1'b1;
    cyc(1);
    stray_done = 1'b0;
    cyc(5);
    n_cmp++;
    if (busy !== 1'b0 || done_cnt !== d0 || start_cnt !== c0 || result !== 16'd147) begin
      n_fail++;
      $display("FAIL stray_done: got busy=%b dones=%0d pulses=%0d result=%0d required 0/0/0/147",
               busy, done_cnt - d0, start_cnt - c0, result);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    bit got;
    run_op(16'd3, 16'd1, 16'd11, 6'd4, 500, got);
    // In the done cycle: this start must be ignored.
    c0      = start_cnt;
    base_m  = 16'd7;
    exp     = 16'd2;
    exp_len = 6'd2;
    start   = 1'b1;
    cyc(1);
    start   = 1'b0;
    cyc(3);
    n_cmp++;
    if (!got || busy !== 1'b0 || start_cnt !== c0) begin
      n_fail++;
      $display("FAIL start_on_done: got done=%0d busy=%b pulses=%0d required 1/0/0",
               got, busy, start_cnt - c0);
    end
    run_op(16'd7, 16'd1, 16'd2, 6'd2, 500, got);
    cyc(3);
    n_cmp++;
    if (!got || result !== 16'd49 || start_cnt - c0 !== 4) begin
      n_fail++;
      $display("FAIL back_to_back: got done=%0d result=%0d pulses=%0d required 1/49/4",
               got, result, start_cnt - c0);
    end
  endtask

  task automatic test_reset_mid();
    int c0, d0;
    bit got;
    c0 = start_cnt;
    d0 = done_cnt;
    base_m  = 16'd3;
    one_m   = 16'd1;
    exp     = 16'd11;
    exp_len = 6'd4;
    start   = 1'b1;
    cyc(1);
    start   = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      cyc(1);
      if (start_cnt - c0 == 2) got = 1'b1;
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL reset_mid_reach_mul: got %0d pulses required 2", start_cnt - c0);
    end
    cyc(1);
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({mm_start, busy, done} !== 3'b000 || result !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got start/busy/done=%b result=%0d required 0",
               {mm_start, busy, done}, result);
    end
    cyc(1);
    rst = 1'b0;
    cyc(10);
    n_cmp++;
    if (busy !== 1'b0 || done_cnt !== d0 || start_cnt - c0 !== 2) begin
      n_fail++;
      $display("FAIL late_mm_done: got busy=%b dones=%0d pulses=%0d required 0/0/2",
               busy, done_cnt - d0, start_cnt - c0);
    end
    c0 = start_cnt;
    run_op(16'd3, 16'd1, 16'd11, 6'd4, 500, got);
    cyc(3);
    n_cmp++;
    if (!got || result !== 16'd147 || start_cnt - c0 !== 8) begin
      n_fail++;
      $display("FAIL after_reset_run: got done=%0d result=%0d pulses=%0d required 1/147/8",
               got, result, start_cnt - c0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_high_bits();
    test_zero_len();
    test_clamp();
    test_busy_ignore();
    test_stray_done();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
